// File: rtl/col_pkg.sv
// Shared sizing helpers and defaults for the column drain buffer.
// Imported by col_bank and col_drain_buffer.
package col_pkg;

  localparam int ROWS_DEF     = 8;
  localparam int OUTWIDTH_DEF = 32;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/col_bank.sv
// One tile bank: per-row data, capture mask and full flag.
// complete looks ahead at this cycle's captures and mask clear.
module col_bank
  import col_pkg::*;
#(
  parameter int ROWS     = ROWS_DEF,
  parameter int OUTWIDTH = OUTWIDTH_DEF
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [ROWS-1:0]          cap_en,
  input  logic [ROWS*OUTWIDTH-1:0] cap_data,
  input  logic                     clear_mask,
  input  logic                     set_full,
  input  logic                     rel,
  output logic                     full,
  output logic                     complete,
  output logic [ROWS-1:0]          mask,
  output logic [ROWS*OUTWIDTH-1:0] data
);

  logic [ROWS-1:0] next_mask;

  assign next_mask = (clear_mask ? '0 : mask) | cap_en;
  assign complete  = &next_mask;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data <= '0;
      mask <= '0;
      full <= 1'b0;
    end else begin
      for (int i = 0; i < ROWS; i++) begin
        if (cap_en[i]) begin
          data[i*OUTWIDTH +: OUTWIDTH] <=
            cap_data[i*OUTWIDTH +: OUTWIDTH];
        end
      end
      mask <= set_full ? '0 : next_mask;
      if (set_full) begin
        full <= 1'b1;
      end else if (rel) begin
        full <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/col_drain_buffer.sv
// Multi-bank column drain buffer: captures per-row results into
// ping-pong banks and serialises completed tiles row 0 first.
module col_drain_buffer
  import col_pkg::*;
#(
  parameter int ROWS     = ROWS_DEF,
  parameter int OUTWIDTH = OUTWIDTH_DEF,
  parameter int BANKS    = 2
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     fire,
  input  logic [ROWS*OUTWIDTH-1:0] in_res,
  input  logic [ROWS-1:0]          in_valids,
  output logic                     in_ready,
  input  logic                     res_read,
  output logic [OUTWIDTH-1:0]      out_r,
  output logic                     rvalid,
  output logic                     out_last,
  output logic                     ovf,
  output logic                     err
);

  localparam int BW = clog2_min1(BANKS);
  localparam int OW = clog2_min1(ROWS);
  localparam int NB = 1 << BW;
  localparam int NR = 1 << OW;

  logic [BW-1:0] wr_bank;
  logic [BW-1:0] rd_bank;
  logic [OW-1:0] ocnt;

  logic [NB-1:0]            full_v;
  logic [NB-1:0]            cmpl_v;
  logic [ROWS-1:0]          mask_v [NB];
  logic [ROWS*OUTWIDTH-1:0] data_v [NB];

  logic                     wr_full;
  logic                     wr_cmpl;
  logic                     rd_go;
  logic                     rd_last;
  logic                     ovf_n;
  logic [ROWS-1:0]          base_mask;
  logic [ROWS-1:0]          cap;
  logic [ROWS*OUTWIDTH-1:0] rd_data;
  logic [OUTWIDTH-1:0]      rows_v [NR];

  function automatic logic [BW-1:0] bump(
    input logic [BW-1:0] p
  );
    return (p == BW'(BANKS - 1)) ? '0 : p + 1'b1;
  endfunction

  // fire wipes the partial tile before this cycle's strobes land
  assign wr_full   = full_v[wr_bank];
  assign base_mask = fire ? '0 : mask_v[wr_bank];
  assign cap       = wr_full ? '0 : (in_valids & ~base_mask);
  assign wr_cmpl   = cmpl_v[wr_bank] & ~wr_full;
  assign ovf_n     = wr_full ? |in_valids
                             : |(in_valids & base_mask);

  assign rvalid   = full_v[rd_bank];
  assign rd_last  = (ocnt == OW'(ROWS - 1));
  assign rd_go    = rvalid & res_read;
  assign out_last = rvalid & rd_last;
  assign in_ready = ~wr_full;

  for (genvar b = 0; b < NB; b++) begin : g_bank
    if (b < BANKS) begin : g_real
      logic is_wr;
      logic is_rd;

      assign is_wr = (wr_bank == BW'(b));
      assign is_rd = (rd_bank == BW'(b));

      col_bank #(
        .ROWS     (ROWS),
        .OUTWIDTH (OUTWIDTH)
      ) u_bank (
        .clk        (clk),
        .rstn       (rstn),
        .cap_en     (is_wr ? cap : '0),
        .cap_data   (in_res),
        .clear_mask (is_wr & fire & ~wr_full),
        .set_full   (is_wr & wr_cmpl),
        .rel        (is_rd & rd_go & rd_last),
        .full       (full_v[b]),
        .complete   (cmpl_v[b]),
        .mask       (mask_v[b]),
        .data       (data_v[b])
      );
    end else begin : g_pad
      assign full_v[b] = 1'b0;
      assign cmpl_v[b] = 1'b0;
      assign mask_v[b] = '0;
      assign data_v[b] = '0;
    end
  end

  assign rd_data = data_v[rd_bank];

  for (genvar r = 0; r < NR; r++) begin : g_row
    if (r < ROWS) begin : g_real
      assign rows_v[r] = rd_data[r*OUTWIDTH +: OUTWIDTH];
    end else begin : g_pad
      assign rows_v[r] = '0;
    end
  end

  assign out_r = rows_v[ocnt];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_bank <= '0;
      rd_bank <= '0;
      ocnt    <= '0;
      ovf     <= 1'b0;
      err     <= 1'b0;
    end else begin
      ovf <= ovf_n;
      err <= err | ovf_n;
      if (wr_cmpl) begin
        wr_bank <= bump(wr_bank);
      end
      if (rd_go) begin
        if (rd_last) begin
          ocnt    <= '0;
          rd_bank <= bump(rd_bank);
        end else begin
          ocnt <= ocnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/col_drain_buffer.md
# col_drain_buffer

Parametrised, multi-bank drain buffer at the bottom of each systolic-array column. It captures one result per row from the column's PEs in any order or skew and holds each completed column tile in one of BANKS ping-pong banks. It then serialises each tile row 0 to ROWS-1 onto a single output port with a valid/read handshake. This lets the array start the next tile while the previous one is still being read out.

## Interface
- ROWS, 8: PEs per column and entries per bank; must be ≥ 2.
- OUTWIDTH, 32: result width in bits.
- BANKS, 2: number of tile banks; must be ≥ 1, with wrap by modulo.
- clk  in  1  clock
- rstn  in  1  asynchronous, active-low reset
- fire  in  1  tile-start strobe; discards any partial capture in the current write bank
- in_res  in  OUTWIDTH x ROWS  per-row results
- in_valids  in  1 x ROWS  per-row capture strobes
- in_ready  out  1  current write bank is free
- res_read  in  1  consumer accepts out_r this cycle
- out_r  out  OUTWIDTH  current output word
- rvalid  out  1  out_r is valid
- out_last  out  1  out_r is row ROWS-1 of its tile
- ovf  out  1  one-cycle pulse when a capture is dropped
- err  out  1  sticky drop flag

## Operation
- State per bank: ROWS x OUTWIDTH data, a ROWS-bit capture mask, and a full bit.
- Pointers: wr_bank and rd_bank, each $clog2(BANKS) bits (minimum 1). ocnt is $clog2(ROWS) bits.
- **Capture (write bank not full):**
  - For each i with in_valids[i]=1 and mask[i]=0, store in_res[i] and set mask[i].
  - Multiple rows may capture in the same cycle.
- **Drop conditions.** In each case the data is discarded, ovf pulses and err is set:
  - in_valids[i]=1 while mask[i] is already 1 (duplicate row).
  - Any in_valids bit high while the write bank is full (no free bank).
- **Tile completion:** when the mask becomes all-ones, including captures made this cycle:
  - set full[wr_bank];
  - clear the mask;
  - advance wr_bank by 1 mod BANKS.
- **fire:**
  - Clears the write-bank mask before same-cycle captures are applied, so those captures belong to the new tile.
  - Has no effect on full banks.
- **Drain:**
  - rvalid = full[rd_bank].
  - out_r = data[rd_bank][ocnt].
  - out_last = rvalid && ocnt == ROWS-1.
- **Read handshake:**
  - rvalid && res_read: ocnt increments.
  - On the read where out_last=1: ocnt returns to 0, full[rd_bank] clears, and rd_bank advances.
  - res_read while rvalid=0 is ignored.
- in_ready = !full[wr_bank].
- No data reordering. Tiles drain strictly in completion order.

## Timing
- **Reset values (async, rstn=0):**
  - all data 0, masks 0, full bits 0, pointers 0, ocnt 0, err 0;
  - outputs: rvalid 0, out_r 0, out_last 0, ovf 0, in_ready 1.
- **Reset mid-operation:** all partial and full tiles are lost. No output is produced until new captures arrive after deassertion.
- **Capture-to-output latency:** the last row captured at edge k gives rvalid=1 in cycle k+1, with out_r = row 0.
- **Throughput:**
  - one word per cycle while res_read is held high;
  - a tile drains in ROWS cycles, and back-to-back full banks drain with no bubble.
- **Bank release:** the release on edge k makes in_ready high from cycle k+1. Same-cycle release and capture into that bank are not merged, and those captures are dropped.
- **Simultaneous complete and drain:** tile completion into wr_bank and tile release of rd_bank in the same cycle are independent and both take effect.
- **BANKS=1:** in_ready stays low from completion until the final read, and capture resumes the cycle after.
- ovf is registered and appears in the cycle after the offending strobe. err is visible in the same cycle as ovf.

## Structure
- **Package col_pkg:**
  - function clog2_min1(n), returning $clog2(n) with a minimum of 1;
  - shared localparams for default ROWS and OUTWIDTH.
- **Sub-module col_bank (ROWS, OUTWIDTH):**
  - owns one bank's data, mask and full bit;
  - inputs: capture enables, clear_mask, set_full, release;
  - outputs: full and complete.
- col_drain_buffer instantiates BANKS copies of col_bank and holds the pointers, ocnt, output mux and error logic.

## Test plan
- **In-order fill and drain** (ROWS=8, BANKS=2, res_read=1): capture rows 0..7 with in_res[i]=0x100+i, one row per cycle → rvalid is high from the cycle after row 7, out_r is 0x100..0x107 over 8 cycles, out_last is high on 0x107, and ovf stays 0.
- **Skewed, simultaneous capture:** in cycle 0 assert rows {7,3,0}, in cycle 1 rows {1,2,4,5,6} → one tile completes at the cycle-1 edge and drains as row 0..7 in index order.
- **Back-pressure and ping-pong:**
  - Hold res_read=0 and fill two tiles (A = 0xA0+i, B = 0xB0+i). in_ready goes low after tile B completes.
  - Assert in_valids[0] during this time → ovf pulses once and err=1.
  - Release res_read → 16 words: the A words, then the B words with no gap. in_ready returns high the cycle after the last A read.
- **Duplicate row and fire:**
  - Capture row 2 = 0x11, then row 2 = 0x22 → ovf pulses and the stored value stays 0x11.
  - Then fire together with row 2 = 0x33, followed by rows 0,1,3..7 → the drained tile has row 2 = 0x33.
- **Reset mid-drain:** assert rstn=0 after 3 of 8 reads → rvalid, out_r, err and ovf are 0 and in_ready=1 immediately. After reset, a fresh tile drains correctly starting from row 0.
- **BANKS=1, ROWS=4:** fill one tile → in_ready stays low until the 4th read, and a capture in the release cycle is dropped with ovf asserted.
